// File: rtl/debouncer_bank_pkg.sv
// rtl/debouncer_bank_pkg.sv - shared constants and helpers for the debouncer bank
package debouncer_bank_pkg;

    localparam int DEB_COUNT    = 6;
    localparam int DEB_PRESCALE = 1;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/deb_tick.sv
// rtl/deb_tick.sv - shared debounce time-base prescaler
module deb_tick
    import debouncer_bank_pkg::*;
#(
    parameter int PRESCALE = DEB_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // A one-bit counter that never leaves zero gives a constant tick when PRESCALE is 1.
    localparam int CW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debouncer_bank.sv
// rtl/debouncer_bank.sv - multi-channel debouncer with edge pulses and shared prescaler
module debouncer_bank
    import debouncer_bank_pkg::*;
#(
    parameter int              WIDTH    = 1,
    parameter int              COUNT    = DEB_COUNT,
    parameter int              PRESCALE = DEB_PRESCALE,
    parameter logic [WIDTH-1:0] INIT    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy,
    output logic             any_event
);

    localparam int              CNTW     = clog2(COUNT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(COUNT - 1);

    logic             tick;
    logic [WIDTH-1:0] s2;

    deb_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic            s1_q;
        logic            s2_q;
        logic            state_q;
        logic            state_d;
        logic            rise_q;
        logic            rise_d;
        logic            fall_q;
        logic            fall_d;
        logic [CNTW-1:0] cnt_q;
        logic [CNTW-1:0] cnt_d;

        // Any return of s2 to the current level discards accumulated ticks.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s2_q == state_q) begin
                cnt_d = '0;
            end else if (tick) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = s2_q;
                    cnt_d   = '0;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q    <= INIT[i];
                s2_q    <= INIT[i];
                state_q <= INIT[i];
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                s1_q    <= in[i];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign s2[i]    = s2_q;
        assign state[i] = state_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

    assign busy      = s2 ^ state;
    assign any_event = |(rise | fall);

endmodule

// File: tb/tb_debouncer_bank.sv
// tb/tb_debouncer_bank.sv - randomized self-checking bench for debouncer_bank
module tb_debouncer_bank;

    typedef struct packed {
        logic [3:0]      s1;
        logic [3:0]      s2;
        logic [3:0]      st;
        logic [3:0]      r;
        logic [3:0]      f;
        logic [3:0][7:0] run;
        logic [31:0]     cyc;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_a = 4'b0000;
    logic [1:0] in_b = 2'b00;

    logic [3:0] state_a, rise_a, fall_a, busy_a;
    logic       any_event_a;
    logic [1:0] state_b, rise_b, fall_b, busy_b;
    logic       any_event_b;

    int vectors = 0;
    int miscompares = 0;

    mdl_t ma;
    mdl_t mb;

    always #5 clk = ~clk;

    debouncer_bank #(
        .WIDTH    (4),
        .COUNT    (6),
        .PRESCALE (1),
        .INIT     (4'b1000)
    ) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_a),
        .state     (state_a),
        .rise      (rise_a),
        .fall      (fall_a),
        .busy      (busy_a),
        .any_event (any_event_a)
    );

    debouncer_bank #(
        .WIDTH    (2),
        .COUNT    (3),
        .PRESCALE (4),
        .INIT     (2'b10)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_b),
        .state     (state_b),
        .rise      (rise_b),
        .fall      (fall_b),
        .busy      (busy_b),
        .any_event (any_event_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic mdl_t mreset(input logic [3:0] init);
        mdl_t m;
        m    = '0;
        m.s1 = init;
        m.s2 = init;
        m.st = init;
        return m;
    endfunction

    // Level changes once the synchronised input has disagreed with it for c consecutive ticks.
    function automatic mdl_t step(input mdl_t m, input int w, input int c, input int p,
                                  input logic [3:0] din);
        mdl_t n;
        logic tick;
        n     = m;
        tick  = ((int'(m.cyc) + 1) % p) == 0;
        n.cyc = m.cyc + 32'd1;
        n.s1  = din;
        n.s2  = m.s1;
        n.r   = '0;
        n.f   = '0;
        for (int i = 0; i < w; i++) begin
            if (m.s2[i] == m.st[i]) begin
                n.run[i] = 8'd0;
            end else if (tick) begin
                if (int'(m.run[i]) + 1 >= c) begin
                    n.st[i]  = m.s2[i];
                    n.run[i] = 8'd0;
                    n.r[i]   = m.s2[i];
                    n.f[i]   = !m.s2[i];
                end else begin
                    n.run[i] = m.run[i] + 8'd1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset(4'b1000);
            mb <= mreset(4'b0010);
        end else begin
            ma <= step(ma, 4, 6, 1, in_a);
            mb <= step(mb, 2, 3, 4, {2'b00, in_b});
        end
    end

    always @(negedge clk) begin
        logic [3:0] bza, bzb, stb, rb, fb;
        bza = ma.s2 ^ ma.st;
        bzb = mb.s2 ^ mb.st;
        stb = mb.st;
        rb  = mb.r;
        fb  = mb.f;
        check("chan_a", 32'({state_a, rise_a, fall_a, busy_a, any_event_a}),
              32'({ma.st, ma.r, ma.f, bza, |(ma.r | ma.f)}));
        check("chan_b", 32'({state_b, rise_b, fall_b, busy_b, any_event_b}),
              32'({stb[1:0], rb[1:0], fb[1:0], bzb[1:0], |(rb[1:0] | fb[1:0])}));
    end

    initial begin
        int npulse;
        int fk;
        int nevt;
        logic [3:0] evt_rise;
        logic [3:0] evt_fall;

        repeat (5) begin
            @(negedge clk);
            in_a = 4'($urandom);
            in_b = 2'($urandom);
        end
        @(posedge clk);
        #1;
        check("reset_b", 32'({state_b, rise_b, fall_b, busy_b}), 32'({2'b10, 6'b0}));
        check("reset_a", 32'({state_a, rise_a, fall_a, busy_a, any_event_a}), 32'({4'b1000, 13'b0}));
        check("model_reset", 32'({ma.st, mb.st}), 32'({4'b1000, 4'b0010}));

        @(negedge clk);
        in_a  = 4'b1000;
        in_b  = 2'b10;
        rst_n = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            check("idle_no_event", 32'({any_event_a, any_event_b, busy_a, busy_b}), 32'd0);
        end

        // Clean rising edge on A channel 0.
        @(negedge clk);
        in_a = 4'b1001;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("clean_busy", 32'(busy_a[0]), 32'd1);
            if (k == 6) check("clean_early", 32'({state_a[0], rise_a[0], busy_a[0]}), 32'(3'b001));
            if (k == 7) begin
                check("clean_edge", 32'({state_a[0], rise_a[0], busy_a[0]}), 32'(3'b110));
                check("model_clean", 32'({ma.st[0], ma.r[0]}), 32'(2'b11));
            end
            if (k == 8) check("clean_pulse_end", 32'({state_a[0], rise_a[0]}), 32'(2'b10));
        end

        // Three-cycle low glitch must not disturb the qualified level.
        @(negedge clk);
        in_a = 4'b1000;
        repeat (3) @(negedge clk);
        in_a = 4'b1001;
        nevt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (any_event_a) nevt++;
        end
        check("bounce_events", 32'(nevt), 32'd0);
        check("bounce_state", 32'(state_a), 32'(4'b1001));

        // Prescaled falling edge on B channel 1.
        @(negedge clk);
        in_b = 2'b00;
        npulse = 0;
        fk = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (fall_b[1]) begin
                npulse++;
                fk = k;
            end
        end
        check("presc_pulses", 32'(npulse), 32'd1);
        check("presc_window", 32'(fk >= 10 && fk <= 14), 32'd1);
        check("presc_state", 32'(state_b), 32'(2'b00));

        @(negedge clk);
        in_b = 2'b01;
        repeat (5) @(negedge clk);
        in_b = 2'b00;
        nevt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (any_event_b) nevt++;
        end
        check("presc_glitch", 32'({nevt[7:0], 6'(state_b)}), 32'd0);

        // Simultaneous changes on A channels 0 and 3 while channel 1 bounces.
        @(negedge clk);
        in_a = 4'b1000;
        repeat (12) @(negedge clk);
        in_a = 4'b0011;
        repeat (2) @(negedge clk);
        in_a = 4'b0001;
        nevt = 0;
        evt_rise = '0;
        evt_fall = '0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (any_event_a) begin
                nevt++;
                evt_rise = rise_a;
                evt_fall = fall_a;
            end
        end
        check("multi_events", 32'(nevt), 32'd1);
        check("multi_edges", 32'({evt_rise, evt_fall}), 32'({4'b0001, 4'b1000}));
        check("multi_state", 32'(state_a), 32'(4'b0001));

        // Reset in the middle of qualification.
        @(negedge clk);
        in_a = 4'b0101;
        for (int k = 0; k <= 5; k++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'({state_a, rise_a, fall_a, any_event_a}), 32'({4'b1000, 9'b0}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) check("midrst_hold", 32'({state_a, any_event_a}), 32'({4'b1000, 1'b0}));
            if (k == 7) check("midrst_requal", 32'({state_a, rise_a, fall_a}),
                              32'({4'b0101, 4'b0101, 4'b1000}));
        end

        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(5, 0) == 0) in_a[$urandom_range(3, 0)] ^= 1'b1;
            if ($urandom_range(9, 0) == 0) in_b[$urandom_range(1, 0)] ^= 1'b1;
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Multi-channel, parametrised switch/button debouncer for the HD44780 front panel and other slow mechanical inputs. Each of WIDTH channels has a two-flop synchroniser, a per-channel stability counter, a registered debounced level, and one-cycle rise and fall pulses. A shared prescaler sets the debounce time base, so long debounce windows need no wide counters. It sits between raw pad inputs and the controller FSMs, replacing single-channel debounce instances.

## Interface
- WIDTH, 1: number of independent channels (≥1).
- COUNT, 6: consecutive stable ticks required before a channel's debounced level changes (≥1).
- PRESCALE, 1: clk cycles per debounce tick (≥1; 1 = tick every cycle).
- INIT, 0: WIDTH-bit reset value of the synchronisers and the debounced level.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  WIDTH  raw asynchronous inputs.
- state  out  WIDTH  debounced level per channel.
- rise  out  WIDTH  one-cycle pulse when state goes 0→1.
- fall  out  WIDTH  one-cycle pulse when state goes 1→0.
- busy  out  WIDTH  channel's synchronised input differs from state (qualification in progress).
- any_event  out  1  OR of all rise and fall bits.

## Operation
- Synchroniser: s1 <= in; s2 <= s1, per channel. Only s2 is used downstream.
- Prescaler: counter 0..PRESCALE-1, wraps; tick = (cnt == PRESCALE-1). With PRESCALE=1, tick is constant 1.
- Per-channel counter, width clog2(COUNT+1):
  - s2 == state: count <= 0 (immediately, regardless of tick).
  - s2 != state, tick, count == COUNT-1: state <= s2, count <= 0, pulse rise or fall by new value.
  - s2 != state, tick, otherwise: count <= count+1.
  - s2 != state, no tick: count holds.
- Bounce during qualification (s2 returns to state) discards progress. There is no partial credit.
- rise and fall are registered and high for exactly one cycle. They are never both set on one channel.
- busy = (s2 != state), combinational from registers. any_event = |(rise|fall).
- Channels are fully independent and share only the tick.

## Timing
- Reset (rst_n low, async): s1 = s2 = state = INIT; count = 0; prescaler = 0; rise = fall = 0. Therefore busy = 0 and any_event = 0 out of reset, with no spurious edge.
- Input changes before edge E0. s2 shows the new value after edge E0+1, and busy rises.
- With PRESCALE=1, state and the rise/fall pulse update at edge E0+1+COUNT. Total latency is COUNT+2 edges from the input change.
- With PRESCALE=P, state updates on the COUNT-th tick edge after s2 mismatches. Latency lies between (COUNT-1)·P+2 and COUNT·P+2 edges, depending on the prescaler phase.
- COUNT=1: state follows s2 on the first tick after a mismatch.
- Simultaneous events: s2 may change in the same cycle the count reaches COUNT-1. Only the registered s2 at that edge decides; if it now matches state, the counter clears.
- Reset asserted mid-qualification: everything aborts to reset values. After release, the first tick occurs PRESCALE cycles later.

## Structure
- Shared header/package: clog2 function, and default constants DEB_COUNT and DEB_PRESCALE for panel inputs.
- Sub-module: deb_tick (prescaler; parameter PRESCALE; ports clk, rst_n, tick). It is instanced once per bank.
- The per-channel logic is a generate loop in debouncer_bank. No further sub-modules.

## Test plan
- Reset: INIT=2'b10, WIDTH=2, rst_n low with in toggling → state=10, rise=fall=busy=0. Release with in=10 → no pulses for 50 cycles.
- Clean edge: COUNT=6, PRESCALE=1, in[0] 0→1 before edge 0 → busy high from edge 1. state[0]=1 and rise[0] pulse for one cycle at edge 7; busy low at edge 7.
- Bounce: in toggles 1→0→1 with a 3-cycle low glitch (COUNT=6) → no state change and no pulse; count returns to 0. A 0→1 edge held for 6 ticks still qualifies.
- Prescale: PRESCALE=4, COUNT=3, in 1→0 held → fall pulse within 10–14 edges of the change, exactly one pulse. A glitch shorter than 2 ticks is rejected.
- Multi-channel: WIDTH=4, channels 0 and 3 change on the same cycle, channel 1 bounces → rise[0] and fall[3] in the same cycle, any_event high for exactly one cycle, channel 1 unchanged.
- Mid-operation reset: rst_n pulsed low at count=4 of 6 → state=INIT immediately, no pulse. Qualification restarts from 0 after release.
